imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the word-addressed instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word to consecutive word addresses starting at 0, holding the CPU core in stall until the image is complete. Sits between the host byte link (UART receiver) and the instruction memory write port.

## Interface

Parameters:
- `DEPTH`, 64, instruction memory depth in words; legal image lengths are 1..DEPTH.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; ignored while `busy`=1.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  32  word address, zero-extended; not a byte address.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  stalls the core while a load is in progress.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky fault flag; cleared by the next accepted `start`.

## Operation

- Byte transfer occurs when `rx_valid` and `rx_ready` are both 1 at a rising edge. Bytes are never dropped or duplicated.
- States and transitions:
  - **IDLE**: `rx_ready`=0. `start`=1 moves to LEN, sets `cpu_hold`=1, clears `error`, and sets word index to 0.
  - **LEN**: `rx_ready`=1. The first byte is word count N.
    - N=0 or N>DEPTH: set `error`=1, drop `cpu_hold`, and return to IDLE.
    - Otherwise latch N and go to DATA.
  - **DATA**: `rx_ready`=1. The k-th accepted byte (k=0..3) loads `mem_wdata[8k+7:8k]`. After the 4th byte, go to WRITE.
  - **WRITE**: `rx_ready`=0 and `mem_we`=1 for exactly one cycle, with `mem_addr`=index. Then increment the index.
    - If index was N-1, go to DONE (or CHECK when the checksum feature is compiled in).
    - Otherwise go to DATA.
  - **DONE**: `done`=1 for one cycle, `cpu_hold` drops, then return to IDLE.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE. Only WRITE asserts `mem_we`.
- `start` asserted in any state other than IDLE is ignored.
- Bytes presented while in IDLE are not accepted.
- Reset is asynchronous. All outputs go to 0 and the state goes to IDLE immediately, including mid-load. Words already written stay in memory; no rollback.

## Timing

- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0.
- `cpu_hold` and `busy` rise one cycle after `start` is sampled.
- `mem_we` asserts in the cycle after the 4th byte of a word is accepted.
- Minimum load with back-to-back bytes:
  - 1 cycle for start, 1 for length, 5·N for the words, 1 for DONE.
  - Add 1 for the checksum byte when compiled in.
- `done` falls and `cpu_hold` falls on the same edge, when the state leaves DONE.
- The word index is 6 bits for DEPTH=64. Termination is on index==N-1, so the index never wraps.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN`:
  - **Defined**: a running XOR of all data bytes (not the length byte) is kept. After the last WRITE, the CHECK state accepts one more byte.
    - Byte equals the XOR: go to DONE.
    - Otherwise: set `error`=1, drop `cpu_hold`, return to IDLE, and `done` is never pulsed. Memory keeps the written words.
  - **Not defined**: there is no CHECK state and no checksum byte; WRITE of the last word goes directly to DONE.

## Test plan

- Reset, then `start`, then stream 0x02, 0xB3,0x06,0x44,0x40, 0xB3,0x06,0x44,0x00 -> writes 0x404406B3 at addr 0 and 0x004406B3 at addr 1, then a single `done` pulse and `cpu_hold` falls.
- Length byte 0x00, then separately 0x41 (DEPTH=64) -> `error`=1, no `mem_we`, back in IDLE; next `start` clears `error`.
- Random `rx_valid` gaps with a 64-word image -> exactly 64 `mem_we` pulses at addresses 0..63 with correct data; `rx_ready` is 0 in every WRITE cycle.
- Drive `reset_n` low after 3 words of a 10-word load -> all outputs 0 immediately; addresses 0..2 keep their data; a new `start` reloads correctly.
- `start` pulses during a load -> ignored; the load completes with unchanged word count.
- With `IMEM_LOADER_CHECKSUM_EN`, 1 word 0x01,0x02,0x03,0x04 then checksum 0x04 -> `done`; then the same word with checksum 0x05 -> `error`=1 and no `done`.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian words written to imem from address 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          accept;

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    error_d = error_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          error_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(DEPTH)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Store N-1 so the index compare fits in IW bits even for N == DEPTH
            last_d  = IW'(rx_data - 8'd1);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{cnt_q, 3'b000} +: 8] = rx_data;
          csum_d = csum_q ^ rx_data;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = 32'(idx_q);
            wdata_d = {rx_data, word_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        if (idx_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the upcoming state
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign cpu_hold  = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; also exercises the checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int DEPTH = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int we_count = 0;
  int done_count = 0;
  int viol = 0;
  int cyc = 0;
  logic [31:0] img    [0:63];
  logic [31:0] tb_mem [0:63];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory write port model and protocol monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      $display("WR   addr=%0d data=%08h", mem_addr, mem_wdata);
      if (mem_addr < 32'd64) tb_mem[mem_addr[5:0]] <= mem_wdata;
      viol <= viol + ((mem_addr >= 32'd64) ? 1 : 0) + ((rx_ready !== 1'b0) ? 1 : 0);
      we_count <= we_count + 1;
    end
    if (done === 1'b1) begin
      $display("DONE pulse at cycle %0d", cyc);
      done_count <= done_count + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) tb_mem[i] = 'x;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    tick(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 100) begin
      tick(1);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_handshake: rx_ready=%b after %0d cycles, required 1", rx_ready, t);
    end
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Sends length byte nlen, then nwords words from img; checksum appended for complete images
  task automatic load(input int nlen, input int nwords, input int maxgap, input bit poke);
    logic [7:0] cs;
    logic [7:0] b;
    logic [31:0] w32;
    cs = 8'd0;
    if (poke) start = 1'b1;
    send_byte(nlen[7:0], 0);
    for (int w = 0; w < nwords; w++) begin
      w32 = img[w];
      for (int k = 0; k < 4; k++) begin
        b  = w32[8*k +: 8];
        cs = cs ^ b;
        send_byte(b, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      end
      n_cmp++;
      if (mem_we !== 1'b1 || rx_ready !== 1'b0 || mem_addr !== 32'(w)) begin
        n_bad++;
        $display("FAIL write_timing: word %0d we=%b rx_ready=%b addr=%0d, required we=1 rx_ready=0 addr=%0d",
                 w, mem_we, rx_ready, mem_addr, w);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nwords == nlen) send_byte(cs, 0);
`endif
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, t);
    end
  endtask

  task automatic test_reset();
    bit bad;
    do_reset();
    n_cmp++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: {rdy,we,hold,busy,done,err}=%b, required 000000",
               {rx_ready, mem_we, cpu_hold, busy, done, error});
    end
    n_cmp++;
    if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: %h, required 0", mem_addr); end
    n_cmp++;
    if (mem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: %h, required 0", mem_wdata); end
    bad = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (rx_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    rx_valid = 1'b0;
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL idle_bytes: rx_ready or busy went 1 in IDLE, required 0"); end
    $display("TXN  reset checks complete");
  endtask

  task automatic test_basic();
    int we0, d0, c0;
    do_reset(); clear_mem();
    we0 = we_count; d0 = done_count;
    img[0] = 32'h404406B3; img[1] = 32'h004406B3;
    c0 = cyc;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      n_bad++; $display("FAIL start_rise: busy=%b hold=%b, required 1 1", busy, cpu_hold);
    end
    load(2, 2, 0, 0);
    wait_done();
    n_cmp++;
    if (cyc - c0 !== 5*2 + 2 + CS_EXTRA) begin
      n_bad++; $display("FAIL load_latency: %0d cycles, required %0d", cyc - c0, 5*2 + 2 + CS_EXTRA);
    end
    n_cmp++;
    if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL hold_in_done: %b, required 1", cpu_hold); end
    tick(1);
    n_cmp++;
    if ({done, cpu_hold, busy} !== 3'b000) begin
      n_bad++; $display("FAIL done_exit: {done,hold,busy}=%b, required 000", {done, cpu_hold, busy});
    end
    tick(2);
    n_cmp++;
    if (we_count - we0 !== 2) begin n_bad++; $display("FAIL basic_we_count: %0d, required 2", we_count - we0); end
    n_cmp++;
    if (tb_mem[0] !== 32'h404406B3) begin n_bad++; $display("FAIL basic_word0: %h, required 404406b3", tb_mem[0]); end
    n_cmp++;
    if (tb_mem[1] !== 32'h004406B3) begin n_bad++; $display("FAIL basic_word1: %h, required 004406b3", tb_mem[1]); end
    n_cmp++;
    if (done_count - d0 !== 1 || error !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: pulses=%0d err=%b, required 1 0", done_count - d0, error);
    end
    $display("TXN  basic 2-word load complete");
  endtask

  task automatic test_bad_length();
    int we0, d0;
    logic [7:0] lens [0:1];
    lens[0] = 8'h00; lens[1] = 8'h41;
    do_reset();
    we0 = we_count; d0 = done_count;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      if (i > 0) begin
        n_cmp++;
        if (error !== 1'b0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL error_clear: err=%b busy=%b, required 0 1", error, busy);
        end
      end
      send_byte(lens[i], 0);
      n_cmp++;
      if ({error, busy, cpu_hold, rx_ready} !== 4'b1000) begin
        n_bad++; $display("FAIL bad_len_%02h: {err,busy,hold,rdy}=%b, required 1000", lens[i],
                          {error, busy, cpu_hold, rx_ready});
      end
      $display("TXN  length %02h rejected", lens[i]);
    end
    tick(3);
    n_cmp++;
    if (we_count != we0 || done_count != d0 || error !== 1'b1) begin
      n_bad++; $display("FAIL bad_len_side: we=%0d done=%0d err=%b, required 0 0 1",
                        we_count - we0, done_count - d0, error);
    end
  endtask

  task automatic test_random_gaps();
    int we0, d0, v0;
    do_reset(); clear_mem();
    we0 = we_count; d0 = done_count; v0 = viol;
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    pulse_start();
    load(64, 64, 3, 0);
    wait_done();
    tick(3);
    n_cmp++;
    if (we_count - we0 !== 64) begin n_bad++; $display("FAIL gaps_we_count: %0d, required 64", we_count - we0); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (tb_mem[i] !== img[i]) begin n_bad++; $display("FAIL gaps_word%0d: %h, required %h", i, tb_mem[i], img[i]); end
    end
    n_cmp++;
    if (viol != v0 || done_count - d0 !== 1) begin
      n_bad++; $display("FAIL gaps_protocol: violations=%0d done=%0d, required 0 1", viol - v0, done_count - d0);
    end
    $display("TXN  64-word load with gaps complete");
  endtask

  task automatic test_reset_mid_load();
    int we0;
    logic [31:0] w3;
    do_reset(); clear_mem();
    we0 = we_count;
    for (int i = 0; i < 10; i++) img[i] = $urandom | 32'h1;
    pulse_start();
    load(10, 3, 1, 0);
    w3 = img[3];
    send_byte(w3[7:0], 0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rx_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_bad++; $display("FAIL async_reset: flags=%b addr=%h wdata=%h, required all 0",
                        {rx_ready, mem_we, cpu_hold, busy, done, error}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    n_cmp++;
    if (we_count - we0 !== 3) begin n_bad++; $display("FAIL partial_we_count: %0d, required 3", we_count - we0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tb_mem[i] !== img[i]) begin n_bad++; $display("FAIL kept_word%0d: %h, required %h", i, tb_mem[i], img[i]); end
    end
    $display("TXN  reset after 3 of 10 words");
    clear_mem();
    for (int i = 0; i < 10; i++) img[i] = img[i] ^ 32'hFFFF_0000;
    pulse_start();
    load(10, 10, 0, 0);
    wait_done();
    tick(2);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (tb_mem[i] !== img[i]) begin n_bad++; $display("FAIL reload_word%0d: %h, required %h", i, tb_mem[i], img[i]); end
    end
    $display("TXN  10-word reload complete");
  endtask

  task automatic test_start_ignored();
    int we0, d0;
    do_reset(); clear_mem();
    we0 = we_count; d0 = done_count;
    img[0] = 32'hDEADBEEF; img[1] = 32'h01234567; img[2] = 32'h89ABCDEF;
    pulse_start();
    load(3, 3, 1, 1);
    wait_done();
    tick(3);
    n_cmp++;
    if (we_count - we0 !== 3 || done_count - d0 !== 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL start_ignored: we=%0d done=%0d busy=%b, required 3 1 0",
                        we_count - we0, done_count - d0, busy);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tb_mem[i] !== img[i]) begin n_bad++; $display("FAIL poke_word%0d: %h, required %h", i, tb_mem[i], img[i]); end
    end
    $display("TXN  load with stray start pulses complete");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int we0, d0;
    do_reset(); clear_mem();
    we0 = we_count; d0 = done_count;
    img[0] = 32'h04030201;
    pulse_start();
    load(1, 1, 0, 0);
    wait_done();
    tick(2);
    n_cmp++;
    if (done_count - d0 !== 1 || error !== 1'b0) begin
      n_bad++; $display("FAIL csum_good: done=%0d err=%b, required 1 0", done_count - d0, error);
    end
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h05, 0);
    tick(3);
    n_cmp++;
    if (done_count - d0 !== 1 || error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL csum_bad: done=%0d err=%b busy=%b hold=%b, required 1 1 0 0",
                        done_count - d0, error, busy, cpu_hold);
    end
    n_cmp++;
    if (we_count - we0 !== 2 || tb_mem[0] !== 32'h04030201) begin
      n_bad++; $display("FAIL csum_mem: we=%0d word0=%h, required 2 04030201", we_count - we0, tb_mem[0]);
    end
    $display("TXN  checksum good/bad complete");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_length();
    test_random_gaps();
    test_reset_mid_load();
    test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
